// File: rtl/rocc_pkg.sv
// Shared RoCC instruction layout and issuer state encoding; also used by accelerators.
package rocc_pkg;

  localparam int unsigned ROCC_FUNCT_W  = 7;
  localparam int unsigned ROCC_REG_W    = 5;
  localparam int unsigned ROCC_OPCODE_W = 7;
  localparam int unsigned ROCC_NREGS    = 1 << ROCC_REG_W;

  typedef logic [ROCC_REG_W-1:0] rocc_reg_t;

  typedef struct packed {
    logic [ROCC_FUNCT_W-1:0]  funct;
    rocc_reg_t                rs2;
    rocc_reg_t                rs1;
    logic                     xd;
    logic                     xs1;
    logic                     xs2;
    rocc_reg_t                rd;
    logic [ROCC_OPCODE_W-1:0] opcode;
  } rocc_inst_t;

  typedef enum logic {
    ST_IDLE,
    ST_FENCE
  } issuer_state_e;

endpackage

// File: rtl/rocc_scoreboard.sv
// Pending-destination bitmap plus count of issued xd=1 commands awaiting a response.
module rocc_scoreboard
  import rocc_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set_i,
  input  rocc_reg_t             set_rd_i,
  input  logic                  clr_i,
  input  rocc_reg_t             clr_rd_i,
  input  logic                  inc_i,
  input  logic                  dec_i,
  input  rocc_reg_t             rs1_i,
  input  rocc_reg_t             rs2_i,
  input  rocc_reg_t             rd_i,
  output logic                  rs1_pend_o,
  output logic                  rs2_pend_o,
  output logic                  rd_pend_o,
  output logic [ROCC_NREGS-1:0] pending_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [ROCC_NREGS-1:0] pending_d, pending_q;
  logic [CNT_W-1:0]      count_d, count_q;
  logic                  dec_eff;

  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_rd_i] = 1'b0;
    // Set is applied after clear so it wins on a same-cycle collision.
    if (set_i) pending_d[set_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    dec_eff = dec_i && (count_q != '0);
    count_d = count_q;
    unique case ({inc_i, dec_eff})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign rs1_pend_o = pending_q[rs1_i];
  assign rs2_pend_o = pending_q[rs2_i];
  assign rd_pend_o  = pending_q[rd_i];
  assign pending_o  = pending_q;
  assign full_o     = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty_o    = (count_q == '0);

  a_no_set_clr_collision: assert property (@(posedge clock) disable iff (reset)
    !(set_i && clr_i && (set_rd_i == clr_rd_i) && (set_rd_i != '0) && pending_q[clr_rd_i]));

endmodule

// File: rtl/rocc_cmd_issuer.sv
// Core-side RoCC master: registered command issue with rd scoreboard, buffered
// response writeback and a fence handshake that waits for the accelerator to drain.
module rocc_cmd_issuer
  import rocc_pkg::*;
#(
  parameter int unsigned XLEN            = 64,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROCC_FUNCT_W-1:0]  in_funct,
  input  logic [ROCC_REG_W-1:0]    in_rs1,
  input  logic [ROCC_REG_W-1:0]    in_rs2,
  input  logic [ROCC_REG_W-1:0]    in_rd,
  input  logic                     in_xs1,
  input  logic                     in_xs2,
  input  logic                     in_xd,
  input  logic [ROCC_OPCODE_W-1:0] in_opcode,
  input  logic [XLEN-1:0]          in_rs1_data,
  input  logic [XLEN-1:0]          in_rs2_data,
  output logic                     rocc_cmd_valid,
  input  logic                     rocc_cmd_ready,
  output logic [ROCC_FUNCT_W-1:0]  rocc_cmd_funct,
  output logic [ROCC_REG_W-1:0]    rocc_cmd_rs1,
  output logic [ROCC_REG_W-1:0]    rocc_cmd_rs2,
  output logic [ROCC_REG_W-1:0]    rocc_cmd_rd,
  output logic                     rocc_cmd_xs1,
  output logic                     rocc_cmd_xs2,
  output logic                     rocc_cmd_xd,
  output logic [ROCC_OPCODE_W-1:0] rocc_cmd_opcode,
  output logic [XLEN-1:0]          rocc_cmd_rs1_data,
  output logic [XLEN-1:0]          rocc_cmd_rs2_data,
  input  logic                     rocc_resp_valid,
  output logic                     rocc_resp_ready,
  input  logic [ROCC_REG_W-1:0]    rocc_resp_rd,
  input  logic [XLEN-1:0]          rocc_resp_data,
  input  logic                     rocc_busy,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [ROCC_REG_W-1:0]    wb_rd,
  output logic [XLEN-1:0]          wb_data,
  input  logic                     fence_valid,
  output logic                     fence_done,
  output logic                     err_unexpected_resp
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  issuer_state_e         state_q;
  rocc_inst_t            cmd_d, cmd_q;
  logic                  cmd_valid_q;
  logic [XLEN-1:0]       rs1_data_q, rs2_data_q;
  logic                  wb_valid_d, wb_valid_q;
  rocc_reg_t             wb_rd_q;
  logic [XLEN-1:0]       wb_data_q;
  logic                  fence_done_q, err_q;

  logic                  rs1_pend, rs2_pend, rd_pend, sb_full, sb_empty;
  logic [ROCC_NREGS-1:0] sb_pending;
  logic                  hazard, accept, resp_capture, unexpected, drained;

  rocc_scoreboard #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .set_i      (accept && in_xd),
    .set_rd_i   (in_rd),
    .clr_i      (resp_capture),
    .clr_rd_i   (rocc_resp_rd),
    .inc_i      (accept && in_xd),
    .dec_i      (resp_capture),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .rd_i       (in_rd),
    .rs1_pend_o (rs1_pend),
    .rs2_pend_o (rs2_pend),
    .rd_pend_o  (rd_pend),
    .pending_o  (sb_pending),
    .full_o     (sb_full),
    .empty_o    (sb_empty)
  );

  assign hazard   = (in_xs1 && rs1_pend) || (in_xs2 && rs2_pend) || (in_xd && rd_pend);
  assign in_ready = (state_q == ST_IDLE) && !fence_valid && (!cmd_valid_q || rocc_cmd_ready)
                    && !hazard && !(in_xd && sb_full);
  assign accept   = in_valid && in_ready;

  always_comb begin
    cmd_d = '{funct: in_funct, rs2: in_rs2, rs1: in_rs1, xd: in_xd, xs1: in_xs1,
              xs2: in_xs2, rd: in_rd, opcode: in_opcode};
  end

  always_ff @(posedge clock) begin
    if (reset)               cmd_valid_q <= 1'b0;
    else if (accept)         cmd_valid_q <= 1'b1;
    else if (rocc_cmd_ready) cmd_valid_q <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      cmd_q      <= cmd_d;
      rs1_data_q <= in_rs1_data;
      rs2_data_q <= in_rs2_data;
    end
  end

  assign rocc_resp_ready = !wb_valid_q || wb_ready;
  assign resp_capture    = rocc_resp_valid && rocc_resp_ready;
  assign unexpected      = resp_capture
                           && (((rocc_resp_rd != '0) && !sb_pending[rocc_resp_rd]) || sb_empty);

  // rd=0 responses are consumed but never presented to the register file.
  always_comb begin
    wb_valid_d = wb_valid_q;
    if (resp_capture)  wb_valid_d = (rocc_resp_rd != '0);
    else if (wb_ready) wb_valid_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      if (unexpected) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (resp_capture) begin
      wb_rd_q   <= rocc_resp_rd;
      wb_data_q <= rocc_resp_data;
    end
  end

  assign drained = !cmd_valid_q && sb_empty && !wb_valid_q && !rocc_busy;

  // An already-drained fence completes straight from IDLE so done follows the request
  // by one cycle; the done cycle itself is not taken as a new request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fence_done_q <= 1'b0;
    end else begin
      fence_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (fence_valid && !fence_done_q) begin
            if (drained) fence_done_q <= 1'b1;
            else         state_q      <= ST_FENCE;
          end
        end
        ST_FENCE: begin
          if (drained) begin
            fence_done_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rocc_cmd_valid      = cmd_valid_q;
  assign rocc_cmd_funct      = cmd_q.funct;
  assign rocc_cmd_rs1        = cmd_q.rs1;
  assign rocc_cmd_rs2        = cmd_q.rs2;
  assign rocc_cmd_rd         = cmd_q.rd;
  assign rocc_cmd_xs1        = cmd_q.xs1;
  assign rocc_cmd_xs2        = cmd_q.xs2;
  assign rocc_cmd_xd         = cmd_q.xd;
  assign rocc_cmd_opcode     = cmd_q.opcode;
  assign rocc_cmd_rs1_data   = rs1_data_q;
  assign rocc_cmd_rs2_data   = rs2_data_q;
  assign wb_valid            = wb_valid_q;
  assign wb_rd               = wb_rd_q;
  assign wb_data             = wb_data_q;
  assign fence_done          = fence_done_q;
  assign err_unexpected_resp = err_q;

endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// Directed bench for rocc_cmd_issuer: a cycle-level reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_rocc_cmd_issuer;

  localparam int MAXO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [6:0]  in_funct, in_opcode;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_xs1, in_xs2, in_xd;
  logic [63:0] in_rs1_data, in_rs2_data;
  logic        rocc_cmd_valid, rocc_cmd_ready;
  logic [6:0]  rocc_cmd_funct, rocc_cmd_opcode;
  logic [4:0]  rocc_cmd_rs1, rocc_cmd_rs2, rocc_cmd_rd;
  logic        rocc_cmd_xs1, rocc_cmd_xs2, rocc_cmd_xd;
  logic [63:0] rocc_cmd_rs1_data, rocc_cmd_rs2_data;
  logic        rocc_resp_valid, rocc_resp_ready;
  logic [4:0]  rocc_resp_rd;
  logic [63:0] rocc_resp_data;
  logic        rocc_busy;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        fence_valid, fence_done, err_unexpected_resp;

  int checks = 0;
  int errors = 0;

  rocc_cmd_issuer #(.XLEN(64), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_xs1(in_xs1), .in_xs2(in_xs2), .in_xd(in_xd), .in_opcode(in_opcode),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .rocc_cmd_valid(rocc_cmd_valid), .rocc_cmd_ready(rocc_cmd_ready),
    .rocc_cmd_funct(rocc_cmd_funct), .rocc_cmd_rs1(rocc_cmd_rs1), .rocc_cmd_rs2(rocc_cmd_rs2),
    .rocc_cmd_rd(rocc_cmd_rd), .rocc_cmd_xs1(rocc_cmd_xs1), .rocc_cmd_xs2(rocc_cmd_xs2),
    .rocc_cmd_xd(rocc_cmd_xd), .rocc_cmd_opcode(rocc_cmd_opcode),
    .rocc_cmd_rs1_data(rocc_cmd_rs1_data), .rocc_cmd_rs2_data(rocc_cmd_rs2_data),
    .rocc_resp_valid(rocc_resp_valid), .rocc_resp_ready(rocc_resp_ready),
    .rocc_resp_rd(rocc_resp_rd), .rocc_resp_data(rocc_resp_data), .rocc_busy(rocc_busy),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .fence_valid(fence_valid), .fence_done(fence_done),
    .err_unexpected_resp(err_unexpected_resp)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_fence = 0, m_done = 0, m_err = 0;
  bit [31:0]   m_pend = '0;
  int          m_out = 0;
  bit          m_cmd_valid = 0;
  logic [6:0]  m_funct, m_opcode;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic        m_xs1, m_xs2, m_xd;
  logic [63:0] m_d1, m_d2;
  bit          m_wb_valid = 0;
  logic [4:0]  m_wb_rd;
  logic [63:0] m_wb_data;

  function automatic bit m_ready();
    bit hz;
    hz = (in_xs1 && m_pend[in_rs1]) || (in_xs2 && m_pend[in_rs2]) || (in_xd && m_pend[in_rd]);
    return !m_fence && !fence_valid && (!m_cmd_valid || rocc_cmd_ready) && !hz
           && !(in_xd && m_out == MAXO);
  endfunction

  always @(posedge clock) begin
    bit acc, cap, drained, nd;
    int dec;
    if (reset) begin
      m_fence = 0; m_done = 0; m_err = 0; m_pend = '0; m_out = 0;
      m_cmd_valid = 0; m_wb_valid = 0;
    end else begin
      acc     = in_valid && m_ready();
      cap     = rocc_resp_valid && (!m_wb_valid || wb_ready);
      drained = !m_cmd_valid && m_out == 0 && !m_wb_valid && !rocc_busy;
      nd = 0;
      if (!m_fence) begin
        if (fence_valid && !m_done) begin
          if (drained) nd = 1; else m_fence = 1;
        end
      end else if (drained) begin
        nd = 1; m_fence = 0;
      end
      dec = 0;
      if (cap) begin
        if ((rocc_resp_rd != 0 && !m_pend[rocc_resp_rd]) || m_out == 0) m_err = 1;
        if (m_out > 0) dec = 1;
        m_pend[rocc_resp_rd] = 1'b0;
        m_wb_valid = (rocc_resp_rd != 0);
        m_wb_rd = rocc_resp_rd;
        m_wb_data = rocc_resp_data;
      end else if (wb_ready) begin
        m_wb_valid = 0;
      end
      if (acc) begin
        if (in_xd && in_rd != 0) m_pend[in_rd] = 1'b1;
        m_cmd_valid = 1;
        m_funct = in_funct; m_opcode = in_opcode; m_rs1 = in_rs1; m_rs2 = in_rs2;
        m_rd = in_rd; m_xs1 = in_xs1; m_xs2 = in_xs2; m_xd = in_xd;
        m_d1 = in_rs1_data; m_d2 = in_rs2_data;
      end else if (rocc_cmd_ready) begin
        m_cmd_valid = 0;
      end
      m_out  = m_out + ((acc && in_xd) ? 1 : 0) - dec;
      m_done = nd;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("in_ready", 64'(in_ready), 64'(m_ready()));
      chk("cmd_valid", 64'(rocc_cmd_valid), 64'(m_cmd_valid));
      if (m_cmd_valid) begin
        chk("cmd_fields", {35'(0), rocc_cmd_funct, rocc_cmd_rs1, rocc_cmd_rs2, rocc_cmd_rd,
                           rocc_cmd_xs1, rocc_cmd_xs2, rocc_cmd_xd, rocc_cmd_opcode},
                          {35'(0), m_funct, m_rs1, m_rs2, m_rd, m_xs1, m_xs2, m_xd, m_opcode});
        chk("cmd_rs1_data", rocc_cmd_rs1_data, m_d1);
        chk("cmd_rs2_data", rocc_cmd_rs2_data, m_d2);
      end
      chk("resp_ready", 64'(rocc_resp_ready), 64'(!m_wb_valid || wb_ready));
      chk("wb_valid", 64'(wb_valid), 64'(m_wb_valid));
      if (m_wb_valid) begin
        chk("wb_rd", 64'(wb_rd), 64'(m_wb_rd));
        chk("wb_data", wb_data, m_wb_data);
      end
      chk("fence_done", 64'(fence_done), 64'(m_done));
      chk("err", 64'(err_unexpected_resp), 64'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [6:0] f, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic x1, input logic x2, input logic xd,
                      input logic [63:0] d1, input logic [63:0] d2);
    in_funct = f; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_xs1 = x1; in_xs2 = x2;
    in_xd = xd; in_opcode = 7'h0B; in_rs1_data = d1; in_rs2_data = d2; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (in_ready) begin
        step(); in_valid = 1'b0;
        return;
      end
      step();
    end
    in_valid = 1'b0; checks++; errors++;
    $display("FAIL send_timeout: in_ready never rose for funct %0h", f);
  endtask

  task automatic resp(input logic [4:0] rd, input logic [63:0] d);
    rocc_resp_rd = rd; rocc_resp_data = d; rocc_resp_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (rocc_resp_ready) begin
        step(); rocc_resp_valid = 1'b0;
        return;
      end
      step();
    end
    rocc_resp_valid = 1'b0; checks++; errors++;
    $display("FAIL resp_timeout: rocc_resp_ready never rose for rd %0d", rd);
  endtask

  initial begin
    int pulses;
    reset = 1; in_valid = 0; in_funct = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_xs1 = 0; in_xs2 = 0; in_xd = 0; in_opcode = 0; in_rs1_data = 0; in_rs2_data = 0;
    rocc_cmd_ready = 1; rocc_resp_valid = 0; rocc_resp_rd = 0; rocc_resp_data = 0;
    rocc_busy = 0; wb_ready = 1; fence_valid = 0;
    repeat (3) step();
    reset = 0;
    chk("rst_cmd_valid", 64'(rocc_cmd_valid), 64'h0);
    chk("rst_wb_valid", 64'(wb_valid), 64'h0);
    chk("rst_fence_done", 64'(fence_done), 64'h0);
    chk("rst_err", 64'(err_unexpected_resp), 64'h0);
    #1 chk("rst_in_ready", 64'(in_ready), 64'h1);
    step();

    // single command and its response
    send(7'h11, 5'd1, 5'd2, 5'd5, 1, 1, 1, 64'h10, 64'h20);
    chk("single_valid", 64'(rocc_cmd_valid), 64'h1);
    chk("single_rd", 64'(rocc_cmd_rd), 64'h5);
    chk("single_funct", 64'(rocc_cmd_funct), 64'h11);
    chk("single_rs1_data", rocc_cmd_rs1_data, 64'h10);
    chk("single_rs2_data", rocc_cmd_rs2_data, 64'h20);
    resp(5'd5, 64'h30);
    chk("single_wb_valid", 64'(wb_valid), 64'h1);
    chk("single_wb_rd", 64'(wb_rd), 64'h5);
    chk("single_wb_data", wb_data, 64'h30);
    in_xd = 1; in_rd = 5; in_xs1 = 0; in_xs2 = 0;
    #1 chk("rd5_cleared", 64'(in_ready), 64'h1);
    step();

    // RAW hazard on rd=7
    send(7'h12, 5'd0, 5'd0, 5'd7, 0, 0, 1, 64'h1, 64'h2);
    in_funct = 7'h22; in_rs1 = 5'd7; in_xs1 = 1; in_xs2 = 0; in_xd = 0; in_rd = 0;
    in_rs1_data = 64'hAA; in_valid = 1;
    repeat (3) begin
      #1 chk("raw_block", 64'(in_ready), 64'h0);
      step();
    end
    rocc_resp_rd = 5'd7; rocc_resp_data = 64'h77; rocc_resp_valid = 1;
    #1 chk("raw_block_cap", 64'(in_ready), 64'h0);
    step(); rocc_resp_valid = 0;
    #1 chk("raw_release", 64'(in_ready), 64'h1);
    step(); in_valid = 0;
    chk("raw_issued_funct", 64'(rocc_cmd_funct), 64'h22);
    chk("raw_issued_rs1", 64'(rocc_cmd_rs1), 64'h7);
    step();

    // command backpressure
    rocc_cmd_ready = 0;
    send(7'h33, 5'd0, 5'd0, 5'd0, 0, 0, 0, 64'h3, 64'h4);
    in_funct = 7'h44; in_rs1_data = 64'h5; in_xs1 = 0; in_xd = 0; in_valid = 1;
    repeat (3) begin
      #1 chk("bp_in_ready", 64'(in_ready), 64'h0);
      chk("bp_hold_funct", 64'(rocc_cmd_funct), 64'h33);
      chk("bp_hold_valid", 64'(rocc_cmd_valid), 64'h1);
      step();
    end
    rocc_cmd_ready = 1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'h1);
    step(); in_valid = 0;
    chk("bp_next_funct", 64'(rocc_cmd_funct), 64'h44);
    step();

    // outstanding limit
    for (int i = 1; i <= MAXO; i++)
      send(7'(8'h50 + i), 5'd0, 5'd0, 5'(i), 0, 0, 1, 64'(i), 64'h0);
    in_funct = 7'h59; in_rd = 5'd9; in_xd = 1; in_xs1 = 0; in_xs2 = 0; in_valid = 1;
    #1 chk("limit_block", 64'(in_ready), 64'h0);
    step();
    #1 chk("limit_block2", 64'(in_ready), 64'h0);
    in_xd = 0;
    #1 chk("limit_xd0_ok", 64'(in_ready), 64'h1);
    step(); in_valid = 0;
    for (int i = 1; i <= MAXO; i++) resp(5'(i), 64'(i * 256));

    // writeback backpressure
    send(7'h60, 5'd0, 5'd0, 5'd12, 0, 0, 1, 64'h0, 64'h0);
    send(7'h61, 5'd0, 5'd0, 5'd13, 0, 0, 1, 64'h0, 64'h0);
    resp(5'd12, 64'hC12);
    wb_ready = 0;
    rocc_resp_rd = 5'd13; rocc_resp_data = 64'hC13; rocc_resp_valid = 1;
    #1 chk("wbbp_resp_ready", 64'(rocc_resp_ready), 64'h0);
    step();
    chk("wbbp_hold_rd", 64'(wb_rd), 64'hC);
    wb_ready = 1;
    #1 chk("wbbp_release", 64'(rocc_resp_ready), 64'h1);
    step(); rocc_resp_valid = 0;
    chk("wbbp_next_data", wb_data, 64'hC13);
    step();

    // fence with outstanding work and a busy accelerator
    send(7'h70, 5'd0, 5'd0, 5'd10, 0, 0, 1, 64'h0, 64'h0);
    send(7'h71, 5'd0, 5'd0, 5'd11, 0, 0, 1, 64'h0, 64'h0);
    rocc_busy = 1; fence_valid = 1;
    repeat (3) begin
      #1 chk("fence_wait", 64'(fence_done), 64'h0);
      chk("fence_in_ready", 64'(in_ready), 64'h0);
      step();
    end
    resp(5'd10, 64'hA0);
    resp(5'd11, 64'hB0);
    repeat (2) begin
      #1 chk("fence_busy", 64'(fence_done), 64'h0);
      step();
    end
    rocc_busy = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (fence_done) begin pulses++; fence_valid = 0; end
      step();
    end
    fence_valid = 0;
    chk("fence_pulses", 64'(pulses), 64'h1);
    #1 chk("fence_resume", 64'(in_ready), 64'h1);
    step();

    // rd=0 response: counted, not written back
    send(7'h72, 5'd0, 5'd0, 5'd0, 0, 0, 1, 64'h0, 64'h0);
    resp(5'd0, 64'h5);
    chk("rd0_no_wb", 64'(wb_valid), 64'h0);
    chk("rd0_no_err", 64'(err_unexpected_resp), 64'h0);
    step();

    // unexpected response
    resp(5'd9, 64'h99);
    chk("unexp_err", 64'(err_unexpected_resp), 64'h1);
    chk("unexp_wb_valid", 64'(wb_valid), 64'h1);
    chk("unexp_wb_rd", 64'(wb_rd), 64'h9);
    chk("unexp_wb_data", wb_data, 64'h99);
    repeat (3) step();
    chk("unexp_sticky", 64'(err_unexpected_resp), 64'h1);
    fence_valid = 1;
    step();
    chk("fence_fast", 64'(fence_done), 64'h1);
    fence_valid = 0;
    step();

    // reset while a command is presented
    rocc_cmd_ready = 0;
    send(7'h7E, 5'd0, 5'd0, 5'd14, 0, 0, 1, 64'h0, 64'h0);
    chk("mid_cmd_valid", 64'(rocc_cmd_valid), 64'h1);
    reset = 1;
    step();
    reset = 0;
    chk("mid_rst_cmd_valid", 64'(rocc_cmd_valid), 64'h0);
    chk("mid_rst_err", 64'(err_unexpected_resp), 64'h0);
    rocc_cmd_ready = 1; in_xd = 1; in_rd = 5'd14; in_xs1 = 0; in_xs2 = 0;
    #1 chk("mid_rst_pend_clr", 64'(in_ready), 64'h1);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rocc_cmd_issuer.md
Name: rocc_cmd_issuer

Overview:
- Core-side master of the RoCC command/response interface.
- Takes decoded custom-opcode instructions with source operands from the pipeline, registers and issues them on rocc_cmd, and tracks outstanding destination registers in a scoreboard.
- Buffers rocc_resp and presents it as an integer register-file writeback.
- Provides a fence handshake that drains the accelerator.
- Sits between the core execute stage and any RoCC accelerator.

Parameters:
- XLEN, 64, operand/response data width.
- MAX_OUTSTANDING, 8, maximum issued commands with xd=1 awaiting a response.
- CNT_W, $clog2(MAX_OUTSTANDING+1), derived width of the outstanding counter (localparam).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_funct  in  7  instruction funct7
- in_rs1  in  5  rs1 index
- in_rs2  in  5  rs2 index
- in_rd  in  5  rd index
- in_xs1  in  1  rs1 value used
- in_xs2  in  1  rs2 value used
- in_xd  in  1  response expected
- in_opcode  in  7  custom opcode
- in_rs1_data  in  XLEN  rs1 value
- in_rs2_data  in  XLEN  rs2 value
- rocc_cmd_valid  out  1  command valid
- rocc_cmd_ready  in  1  accelerator accepts command
- rocc_cmd_funct / rs1 / rs2 / rd / xs1 / xs2 / xd / opcode  out  7/5/5/5/1/1/1/7  registered instruction fields
- rocc_cmd_rs1_data / rocc_cmd_rs2_data  out  XLEN  registered operands
- rocc_resp_valid  in  1  response valid
- rocc_resp_ready  out  1  response accepted
- rocc_resp_rd  in  5  response destination
- rocc_resp_data  in  XLEN  response data
- rocc_busy  in  1  accelerator busy
- wb_valid  out  1  writeback valid
- wb_ready  in  1  register-file port granted
- wb_rd  out  5  writeback destination
- wb_data  out  XLEN  writeback data
- fence_valid  in  1  fence request (level; held until fence_done)
- fence_done  out  1  one-cycle pulse: accelerator drained
- err_unexpected_resp  out  1  sticky: response for an rd not pending

Behaviour:
- Reset values:
  - rocc_cmd_valid=0, wb_valid=0, fence_done=0, err_unexpected_resp=0.
  - Scoreboard pending[31:0]=0, outstanding counter=0, state=IDLE.
  - Data registers don't-care.
- Command register, one entry:
  - in_ready = state==IDLE && !fence_valid && (!rocc_cmd_valid || rocc_cmd_ready) && !hazard && !(in_xd && outstanding==MAX_OUTSTANDING).
  - hazard = (in_xs1 && pending[in_rs1]) || (in_xs2 && pending[in_rs2]) || (in_xd && pending[in_rd]), evaluated on the current registered scoreboard.
  - Index 0 never reads as pending.
  - On accept, the fields load into the output register and rocc_cmd_valid=1 the next cycle (1-cycle latency).
  - Outputs hold stable while valid && !ready.
  - Full-throughput back-to-back issue when rocc_cmd_ready=1.
- Scoreboard and counter:
  - On accept with in_xd=1: outstanding+1; pending[in_rd] set if in_rd!=0.
  - On response capture: outstanding-1; pending[rocc_resp_rd] cleared.
  - Increment and decrement in the same cycle leave the counter unchanged.
  - If one cycle both sets and clears the same bit, set wins. The hazard rule makes this unreachable; an assertion covers it.
- Response path, one-entry buffer:
  - rocc_resp_ready = !wb_valid || wb_ready.
  - A capture loads wb_rd/wb_data and sets wb_valid the next cycle.
  - wb_valid clears on wb_ready unless a new response is captured the same cycle.
  - A response with rd=0 is consumed and decrements the counter, but wb_valid stays low.
  - A response whose rd is nonzero and not pending, or arriving with outstanding==0, sets err_unexpected_resp until reset. The counter saturates at 0; the data is still written back.
- FSM {IDLE, FENCE}:
  - IDLE -> FENCE when fence_valid=1; in_ready is forced low from that cycle.
  - FENCE exit: fence_done pulses for one cycle and the FSM returns to IDLE when !rocc_cmd_valid && outstanding==0 && !wb_valid && !rocc_busy.
  - If already drained, fence_done rises the cycle after fence_valid rises.
- Reset mid-operation clears all state. A command already presented is dropped: rocc_cmd_valid falls regardless of rocc_cmd_ready.

Decomposition:
- Package rocc_pkg holds:
  - ROCC_FUNCT_W=7, ROCC_REG_W=5, ROCC_OPCODE_W=7.
  - Packed struct rocc_inst_t {funct, rs2, rs1, xd, xs1, xs2, rd, opcode}, shared with accelerators.
- One natural sub-module: rocc_scoreboard. It holds pending bits plus the outstanding counter, with set/clear ports and the three hazard lookups.

Test Plan:
- Single cmd, xd=1, rd=5, rs1=0x10, rs2=0x20, cmd_ready=1: rocc_cmd_valid 1 cycle after accept with the fields intact. Respond rd=5, data=0x30: wb_valid next cycle, wb_rd=5, wb_data=0x30, pending[5] cleared.
- RAW hazard: cmd xd rd=7 outstanding, next instruction xs1=1 rs1=7: in_ready=0 until the rd=7 response is captured, then accepted the following cycle.
- Backpressure: hold rocc_cmd_ready=0 for 3 cycles: cmd outputs stable, in_ready=0. Release: issue completes and a new accept occurs the same cycle.
- Outstanding limit: issue 8 xd=1 commands to distinct rds with no responses: in_ready=0 on the 9th xd=1 instruction. An xd=0 instruction still issues.
- Fence: 2 outstanding, rocc_busy=1: fence_done stays 0. After both responses are written back and rocc_busy=0: fence_done pulses exactly once and in_ready resumes.
- Unexpected response rd=9 with nothing pending: err_unexpected_resp=1 and stays 1. Outstanding stays 0, wb_rd=9 written.
